vram_ahb_ctrl: RTL and testbench

Parametrised AHB-Lite framebuffer slave for the SWORD MIPSfpga system. It sits on the AHB data bus next to the other memory slaves. It stores `PIX_W`-bit pixels, one per 32-bit word, and adds the following features:
- byte-lane writes;
- a wait state when a write data phase collides with a read;
- an AHB ERROR response for illegal transfers;
- a single-clock scan-out read port for the display pipeline.

---
 rtl/vram_ahb_ctrl_pkg.sv | 48 ++++
 rtl/vram_bram.sv | 54 +++++
 rtl/vram_ahb_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_vram_ahb_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_ahb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_ahb_ctrl_pkg
// Description : Shared AHB-Lite constants, FSM state encoding and lane-enable
//               helper for the framebuffer slave.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_ahb_ctrl_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB transfer sizes used by this slave
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // AHB responses
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Slave FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } st_t;

    // Byte-lane enables for a legal (already size/alignment checked) transfer
    function automatic logic [3:0] ahb_byte_en(input logic [2:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_bram.sv
`default_nettype none
// ============================================================================
// Module      : vram_bram
// Description : Simple dual-port RAM. Port A read/write with per-byte-lane
//               write enables, port B read-only. Both reads are registered
//               and read-first on a same-address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_bram #(
    parameter int ADDR_W = 19,
    parameter int LANES  = 2
) (
    input  logic                 clk,
    input  logic                 i_a_en,
    input  logic [LANES-1:0]     i_a_we,
    input  logic [ADDR_W-1:0]    i_a_addr,
    input  logic [LANES*8-1:0]   i_a_din,
    output logic [LANES*8-1:0]   o_a_dout,
    input  logic                 i_b_en,
    input  logic [ADDR_W-1:0]    i_b_addr,
    output logic [LANES*8-1:0]   o_b_dout
);

    localparam int MEM_W = LANES * 8;

    // Storage is padded to whole lanes so each lane is a plain byte write
    logic [MEM_W-1:0] r_mem [2**ADDR_W];
    logic [MEM_W-1:0] r_a_dout;
    logic [MEM_W-1:0] r_b_dout;

    // Port A: registered read of the old word, then byte-lane writes
    always_ff @(posedge clk) begin
        if (i_a_en) begin
            r_a_dout <= r_mem[i_a_addr];
            for (int k = 0; k < LANES; k++) begin
                if (i_a_we[k]) begin
                    r_mem[i_a_addr][k*8 +: 8] <= i_a_din[k*8 +: 8];
                end
            end
        end
    end

    // Port B: registered read-only port
    always_ff @(posedge clk) begin
        if (i_b_en) begin
            r_b_dout <= r_mem[i_b_addr];
        end
    end

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;

endmodule
`default_nettype wire

// File: rtl/vram_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vram_ahb_ctrl
// Description : AHB-Lite framebuffer slave. One PIX_W-bit pixel per 32-bit
//               word, byte-lane writes, a wait state when a read collides
//               with a write data phase, two-cycle ERROR for illegal
//               transfers and an independent scan-out read port.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_ahb_ctrl
    import vram_ahb_ctrl_pkg::*;
#(
    parameter int          PIX_W  = 12,
    parameter int          ADDR_W = 19,
    parameter logic [31:0] BASE   = 32'h1F40_0000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    input  logic              SCAN_EN,
    input  logic [ADDR_W-1:0] SCAN_ADDR,
    output logic [PIX_W-1:0]  SCAN_DATA,
    output logic              SCAN_VALID
);

    localparam int LANES = (PIX_W + 7) / 8;
    localparam int MEM_W = LANES * 8;

    st_t                r_st;
    st_t                w_st_nxt;
    logic               r_wr_pend;
    logic [ADDR_W-1:0]  r_wr_idx;
    logic [3:0]         r_wr_be;
    logic [ADDR_W-1:0]  r_rd_idx;
    logic               r_rd_valid;
    logic               r_scan_valid;

    logic               w_rdy_state;
    logic               w_accept;
    logic [31:0]        w_off;
    logic               w_in_range;
    logic               w_misalign;
    logic               w_illegal;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_rd_issue;
    logic               w_a_en;
    logic [LANES-1:0]   w_a_we;
    logic [ADDR_W-1:0]  w_a_addr;
    logic [MEM_W-1:0]   w_a_din;
    logic [MEM_W-1:0]   w_a_dout;
    logic [MEM_W-1:0]   w_b_dout;
    logic               w_unused;

    // Address decode and legality of the transfer on the bus this cycle
    always_comb begin
        w_rdy_state = (r_st == ST_IDLE) || (r_st == ST_ERR2);
        w_accept    = HSEL & HREADY & HTRANS[1] & w_rdy_state;
        w_off       = HADDR - BASE;
        w_in_range  = ((w_off >> (ADDR_W + 2)) == 32'd0);
        w_misalign  = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
        w_illegal   = (HSIZE > HSIZE_WORD) || w_misalign || !w_in_range;
        w_idx       = HADDR[ADDR_W+1:2];
    end

    // RAM port A arbitration: pending write data phase wins, STALL reissues
    always_comb begin
        w_rd_issue = (r_st == ST_STALL) ||
                     (w_accept && !w_illegal && !HWRITE && !r_wr_pend);
        w_a_en     = r_wr_pend || w_rd_issue;
        w_a_we     = r_wr_pend ? r_wr_be[LANES-1:0] : '0;
        if (r_wr_pend) begin
            w_a_addr = r_wr_idx;
        end else if (r_st == ST_STALL) begin
            w_a_addr = r_rd_idx;
        end else begin
            w_a_addr = w_idx;
        end
        w_a_din    = HWDATA[MEM_W-1:0];
    end

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    // FSM next state and bus handshake outputs
    always_comb begin
        w_st_nxt  = ST_IDLE;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (r_st)
            ST_IDLE, ST_ERR2: begin
                if (r_st == ST_ERR2) begin
                    HRESP = HRESP_ERROR;
                end
                if (w_accept) begin
                    if (w_illegal) begin
                        w_st_nxt = ST_ERR1;
                    end else if (!HWRITE && r_wr_pend) begin
                        w_st_nxt = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                HREADYOUT = 1'b0;
                w_st_nxt  = ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                w_st_nxt  = ST_ERR2;
            end
            default: begin
                w_st_nxt  = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted address phase; a write becomes pending for one data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_pend <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_be   <= 4'b0000;
            r_rd_idx  <= '0;
        end else begin
            r_wr_pend <= w_accept && HWRITE && !w_illegal;
            if (w_accept) begin
                r_wr_idx <= w_idx;
                r_wr_be  <= ahb_byte_en(HSIZE, HADDR[1:0]);
                r_rd_idx <= w_idx;
            end
        end
    end

    // Read-data qualifiers: AHB read data phase and delayed scan enable
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rd_valid   <= 1'b0;
            r_scan_valid <= 1'b0;
        end else begin
            r_rd_valid   <= w_rd_issue;
            r_scan_valid <= SCAN_EN;
        end
    end

    vram_bram #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_ram (
        .clk      (HCLK),
        .i_a_en   (w_a_en),
        .i_a_we   (w_a_we),
        .i_a_addr (w_a_addr),
        .i_a_din  (w_a_din),
        .o_a_dout (w_a_dout),
        .i_b_en   (SCAN_EN),
        .i_b_addr (SCAN_ADDR),
        .o_b_dout (w_b_dout)
    );

    // Read data is zero outside a valid data phase so reset shows zeros
    always_comb begin
        HRDATA = '0;
        if (r_rd_valid) begin
            HRDATA[PIX_W-1:0] = w_a_dout[PIX_W-1:0];
        end
        SCAN_DATA  = r_scan_valid ? w_b_dout[PIX_W-1:0] : '0;
        SCAN_VALID = r_scan_valid;
    end

    // Bits of the bus and padded RAM words that carry no pixel information
    assign w_unused = ^{HTRANS[0], HWDATA, w_a_dout, w_b_dout, r_wr_be};

endmodule
`default_nettype wire

// File: tb/tb_vram_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_ahb_ctrl
// Description : Directed self-checking bench for the AHB framebuffer slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_ahb_ctrl;
    import vram_ahb_ctrl_pkg::*;

    localparam logic [31:0] C_BASE = 32'h1F40_0000;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        SCAN_EN;
    logic [18:0] SCAN_ADDR;
    logic [11:0] SCAN_DATA;
    logic        SCAN_VALID;

    int n_checks;
    int n_fails;

    // Single slave on the bus: the bus ready is this slave's ready
    assign HREADY = HREADYOUT;

    vram_ahb_ctrl dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HREADY     (HREADY),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .SCAN_EN    (SCAN_EN),
        .SCAN_ADDR  (SCAN_ADDR),
        .SCAN_DATA  (SCAN_DATA),
        .SCAN_VALID (SCAN_VALID)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_set(input logic wr, input logic [31:0] addr, input logic [2:0] size);
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
    endtask

    task automatic ahb_idle;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        ahb_set(1'b1, addr, size);
        tick;
        HWDATA = data;
        ahb_idle;
        tick;
    endtask

    task automatic test_reset;
        HRESETn   = 1'b0;
        ahb_idle;
        HADDR     = 32'h0;
        HSIZE     = HSIZE_WORD;
        HWDATA    = 32'h0;
        SCAN_EN   = 1'b0;
        SCAN_ADDR = '0;
        tick;
        tick;
        n_checks++; if (HRDATA !== 32'h0)     begin n_fails++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
        n_checks++; if (HREADYOUT !== 1'b1)   begin n_fails++; $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0)       begin n_fails++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
        n_checks++; if (SCAN_DATA !== 12'h0)  begin n_fails++; $display("FAIL reset_scan_data: got %h want 0", SCAN_DATA); end
        n_checks++; if (SCAN_VALID !== 1'b0)  begin n_fails++; $display("FAIL reset_scan_valid: got %b want 0", SCAN_VALID); end
        HRESETn = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        ahb_set(1'b1, C_BASE + 32'h10, HSIZE_WORD);
        tick;
        HWDATA = 32'h0000_0ABC;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL basic_wr_ready: got %b want 1", HREADYOUT); end
        tick;
        ahb_set(1'b0, C_BASE + 32'h10, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b1)      begin n_fails++; $display("FAIL basic_rd_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0)          begin n_fails++; $display("FAIL basic_rd_resp: got %b want 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0000_0ABC) begin n_fails++; $display("FAIL basic_rd_data: got %h want 00000abc", HRDATA); end
        tick;
    endtask

    task automatic test_back_to_back;
        ahb_set(1'b1, C_BASE + 32'h10, HSIZE_WORD);
        tick;
        HWDATA = 32'h0000_0123;
        ahb_set(1'b0, C_BASE + 32'h10, HSIZE_WORD);
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL b2b_wr_phase_ready: got %b want 1", HREADYOUT); end
        tick;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b0) begin n_fails++; $display("FAIL b2b_stall_ready: got %b want 0", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0)     begin n_fails++; $display("FAIL b2b_stall_resp: got %b want 0", HRESP); end
        tick;
        n_checks++; if (HREADYOUT !== 1'b1)       begin n_fails++; $display("FAIL b2b_done_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRDATA !== 32'h0000_0123) begin n_fails++; $display("FAIL b2b_rd_data: got %h want 00000123", HRDATA); end
        // Two pipelined reads with no wait states
        ahb_set(1'b0, C_BASE + 32'h10, HSIZE_WORD);
        tick;
        ahb_set(1'b0, C_BASE + 32'h10, HSIZE_WORD);
        n_checks++; if (HRDATA !== 32'h0000_0123) begin n_fails++; $display("FAIL b2b_pipe_rd1: got %h want 00000123", HRDATA); end
        tick;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b1)       begin n_fails++; $display("FAIL b2b_pipe_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRDATA !== 32'h0000_0123) begin n_fails++; $display("FAIL b2b_pipe_rd2: got %h want 00000123", HRDATA); end
        tick;
    endtask

    task automatic test_byte_write;
        ahb_write(C_BASE + 32'h20, HSIZE_WORD, 32'h0000_0ABC);
        ahb_write(C_BASE + 32'h21, HSIZE_BYTE, 32'h0000_5F00);
        ahb_set(1'b0, C_BASE + 32'h20, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HRDATA !== 32'h0000_0FBC) begin n_fails++; $display("FAIL byte_lane1: got %h want 00000fbc", HRDATA); end
        tick;
        ahb_set(1'b1, C_BASE + 32'h22, HSIZE_BYTE);
        tick;
        HWDATA = 32'h00AA_0000;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL byte_lane2_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0)     begin n_fails++; $display("FAIL byte_lane2_resp: got %b want 0", HRESP); end
        tick;
        ahb_set(1'b0, C_BASE + 32'h20, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HRDATA !== 32'h0000_0FBC) begin n_fails++; $display("FAIL byte_lane2_kept: got %h want 00000fbc", HRDATA); end
        tick;
        ahb_write(C_BASE + 32'h20, HSIZE_HALF, 32'hFFFF_0456);
        ahb_set(1'b0, C_BASE + 32'h20, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HRDATA !== 32'h0000_0456) begin n_fails++; $display("FAIL half_low: got %h want 00000456", HRDATA); end
        tick;
    endtask

    task automatic test_errors;
        ahb_write(C_BASE, HSIZE_WORD, 32'h0000_0321);
        // Misaligned word read
        ahb_set(1'b0, C_BASE + 32'h2, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b0) begin n_fails++; $display("FAIL err_mis_c1_ready: got %b want 0", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b1)     begin n_fails++; $display("FAIL err_mis_c1_resp: got %b want 1", HRESP); end
        tick;
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL err_mis_c2_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b1)     begin n_fails++; $display("FAIL err_mis_c2_resp: got %b want 1", HRESP); end
        tick;
        n_checks++; if (HRESP !== 1'b0)     begin n_fails++; $display("FAIL err_mis_after_resp: got %b want 0", HRESP); end
        // Doubleword write, next read issued during the second error cycle
        ahb_set(1'b1, C_BASE, 3'b011);
        tick;
        HWDATA = 32'h0000_0FFF;
        ahb_idle;
        n_checks++; if (HREADYOUT !== 1'b0) begin n_fails++; $display("FAIL err_dw_c1_ready: got %b want 0", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b1)     begin n_fails++; $display("FAIL err_dw_c1_resp: got %b want 1", HRESP); end
        tick;
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fails++; $display("FAIL err_dw_c2_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b1)     begin n_fails++; $display("FAIL err_dw_c2_resp: got %b want 1", HRESP); end
        ahb_set(1'b0, C_BASE, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HRESP !== 1'b0)           begin n_fails++; $display("FAIL err_dw_next_resp: got %b want 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0000_0321) begin n_fails++; $display("FAIL err_dw_ram_kept: got %h want 00000321", HRDATA); end
        tick;
        // Out-of-range write that would alias index 0
        ahb_set(1'b1, C_BASE + 32'h0020_0000, HSIZE_WORD);
        tick;
        HWDATA = 32'h0000_0EEE;
        ahb_idle;
        n_checks++; if (HRESP !== 1'b1) begin n_fails++; $display("FAIL err_range_resp: got %b want 1", HRESP); end
        tick;
        tick;
        ahb_set(1'b0, C_BASE, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HRDATA !== 32'h0000_0321) begin n_fails++; $display("FAIL err_range_ram_kept: got %h want 00000321", HRDATA); end
        tick;
    endtask

    task automatic test_scan;
        ahb_write(C_BASE + 32'h1C, HSIZE_WORD, 32'h0000_0111);
        SCAN_EN   = 1'b1;
        SCAN_ADDR = 19'd7;
        ahb_set(1'b1, C_BASE + 32'h1C, HSIZE_WORD);
        tick;
        HWDATA = 32'h0000_0777;
        ahb_idle;
        n_checks++; if (SCAN_VALID !== 1'b1)   begin n_fails++; $display("FAIL scan_valid: got %b want 1", SCAN_VALID); end
        n_checks++; if (SCAN_DATA !== 12'h111) begin n_fails++; $display("FAIL scan_pre: got %h want 111", SCAN_DATA); end
        tick;
        n_checks++; if (SCAN_DATA !== 12'h111) begin n_fails++; $display("FAIL scan_collision_old: got %h want 111", SCAN_DATA); end
        tick;
        n_checks++; if (SCAN_DATA !== 12'h777) begin n_fails++; $display("FAIL scan_after_write: got %h want 777", SCAN_DATA); end
        SCAN_ADDR = 19'd4;
        tick;
        SCAN_ADDR = 19'd8;
        n_checks++; if (SCAN_DATA !== 12'h123) begin n_fails++; $display("FAIL scan_idx4: got %h want 123", SCAN_DATA); end
        tick;
        SCAN_EN = 1'b0;
        n_checks++; if (SCAN_DATA !== 12'h456) begin n_fails++; $display("FAIL scan_idx8: got %h want 456", SCAN_DATA); end
        tick;
        n_checks++; if (SCAN_VALID !== 1'b0)   begin n_fails++; $display("FAIL scan_valid_drop: got %b want 0", SCAN_VALID); end
    endtask

    task automatic test_reset_mid_write;
        ahb_write(C_BASE + 32'h24, HSIZE_WORD, 32'h0000_00AA);
        SCAN_EN   = 1'b1;
        SCAN_ADDR = 19'd9;
        ahb_set(1'b1, C_BASE + 32'h24, HSIZE_WORD);
        tick;
        HWDATA = 32'h0000_0555;
        ahb_idle;
        #1;
        HRESETn = 1'b0;
        SCAN_EN = 1'b0;
        #1;
        n_checks++; if (HRDATA !== 32'h0)    begin n_fails++; $display("FAIL rst_mid_hrdata: got %h want 0", HRDATA); end
        n_checks++; if (HREADYOUT !== 1'b1)  begin n_fails++; $display("FAIL rst_mid_ready: got %b want 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0)      begin n_fails++; $display("FAIL rst_mid_resp: got %b want 0", HRESP); end
        n_checks++; if (SCAN_VALID !== 1'b0) begin n_fails++; $display("FAIL rst_mid_scan_valid: got %b want 0", SCAN_VALID); end
        n_checks++; if (SCAN_DATA !== 12'h0) begin n_fails++; $display("FAIL rst_mid_scan_data: got %h want 0", SCAN_DATA); end
        tick;
        tick;
        HRESETn = 1'b1;
        tick;
        ahb_set(1'b0, C_BASE + 32'h24, HSIZE_WORD);
        tick;
        ahb_idle;
        n_checks++; if (HRDATA !== 32'h0000_00AA) begin n_fails++; $display("FAIL rst_mid_ram_kept: got %h want 000000aa", HRDATA); end
        tick;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_byte_write;
        test_errors;
        test_scan;
        test_reset_mid_write;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
